// File: rtl/data_mem_responder.sv
// Data-port responder for the pipelined core: word RAM plus a 4-word I/O block
// (GPIO out, synchronized GPIO in, cycle counter, sticky W1C error status).
module data_mem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    RAM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = ADDR_WIDTH'(32'h1001_0000),
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h1001_0400),
  parameter int                    GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic [GPIO_WIDTH-1:0] GPIO_In,
  output logic [GPIO_WIDTH-1:0] GPIO_Out,
  output logic                  Err
);

  localparam int                    IDX_W     = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(4 * RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] IO_BYTES  = ADDR_WIDTH'(16);

  logic [ADDR_WIDTH-1:0] ram_off, io_off;
  logic                  access, misalign, ram_hit, io_hit, unmapped;
  logic                  valid_wr, ram_we, io_we;
  logic [IDX_W-1:0]      ram_idx;
  logic [1:0]            io_sel;

  // Unsigned wrap makes an address below the base look huge, so one compare
  // covers both ends of each window.
  assign ram_off  = Address - RAM_BASE;
  assign io_off   = Address - IO_BASE;
  assign ram_hit  = (ram_off < RAM_BYTES);
  assign io_hit   = (io_off < IO_BYTES);
  assign ram_idx  = ram_off[IDX_W+1:2];
  assign io_sel   = io_off[3:2];
  assign access   = MemRead | MemWrite;
  assign misalign = access & (Address[1:0] != 2'b00);
  assign unmapped = access & ~misalign & ~ram_hit & ~io_hit;
  assign valid_wr = MemWrite & ~misalign & ~unmapped;
  assign ram_we   = valid_wr & ram_hit & rst;
  assign io_we    = valid_wr & ~ram_hit & io_hit;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= WriteData;
  end

  logic [DATA_WIDTH-1:0] read_data_reg, read_data_next, io_rdata;
  logic [DATA_WIDTH-1:0] cycle_reg, cycle_next;
  logic [GPIO_WIDTH-1:0] gpio_out_reg, gpio_out_next;
  logic [GPIO_WIDTH-1:0] sync1_reg, sync2_reg;
  logic [1:0]            status_reg, status_next, status_set, status_clr;
  logic                  err_reg;

  always_comb begin
    io_rdata = '0;
    case (io_sel)
      2'd0:    io_rdata = {{(DATA_WIDTH-GPIO_WIDTH){1'b0}}, gpio_out_reg};
      2'd1:    io_rdata = {{(DATA_WIDTH-GPIO_WIDTH){1'b0}}, sync2_reg};
      2'd2:    io_rdata = cycle_reg;
      default: io_rdata = {{(DATA_WIDTH-2){1'b0}}, status_reg};
    endcase
  end

  always_comb begin
    read_data_next = '0;
    if (!misalign && !unmapped) begin
      if (ram_hit) read_data_next = mem[ram_idx];
      else         read_data_next = io_rdata;
    end
  end

  assign cycle_next    = (io_we && io_sel == 2'd2) ? WriteData : cycle_reg + 1'b1;
  assign gpio_out_next = (io_we && io_sel == 2'd0) ? WriteData[GPIO_WIDTH-1:0] : gpio_out_reg;
  assign status_set    = {unmapped, misalign};
  assign status_clr    = (io_we && io_sel == 2'd3) ? WriteData[1:0] : 2'b00;

  // A new error outranks a simultaneous write-1-to-clear of the same bit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_status
      assign status_next[gi] = status_set[gi] | (status_reg[gi] & ~status_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_reg <= '0;
      cycle_reg     <= '0;
      gpio_out_reg  <= '0;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      status_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (MemRead) read_data_reg <= read_data_next;
      cycle_reg    <= cycle_next;
      gpio_out_reg <= gpio_out_next;
      sync1_reg    <= GPIO_In;
      sync2_reg    <= sync1_reg;
      status_reg   <= status_next;
      err_reg      <= |status_next;
    end
  end

  assign ReadData = read_data_reg;
  assign GPIO_Out = gpio_out_reg;
  assign Err      = err_reg;

endmodule
